// File: rtl/mpi_ram_slave_if.sv
// MPI/Q-bus slave-side signal bundle. All bus levels are active-low; ad_* carry inverted data.
interface mpi_ram_slave_if;
    logic        init_n;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic [15:0] ad_in_n;
    logic [15:0] ad_out_n;
    logic        ad_oe;
    logic        rply_n;
    logic        sel;

    modport master (
        output init_n, sync_n, din_n, dout_n, wtbt_n, ad_in_n,
        input  ad_out_n, ad_oe, rply_n, sel
    );

    modport slave (
        input  init_n, sync_n, din_n, dout_n, wtbt_n, ad_in_n,
        output ad_out_n, ad_oe, rply_n, sel
    );
endinterface

// File: rtl/mpi_ram_slave.sv
// Block-RAM responder for the vm1 MPI bus: decodes an address window and answers
// DIN/DOUT strobes (including read-modify-write) with RPLY.
module mpi_ram_slave #(
    parameter logic [15:0] BASE = 16'o100000,
    parameter int          AW   = 12,
    parameter int          WAIT = 0
) (
    input  logic           clk,
    input  logic           rst,
    mpi_ram_slave_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD} state_t;

    localparam int          SW      = 21;
    localparam logic [16:0] WIN_LO  = {1'b0, BASE};
    localparam logic [16:0] WIN_HI  = WIN_LO + (17'd1 << (AW + 1));
    localparam logic [3:0]  WAIT_M1 = 4'(WAIT - 1);

    // Two-stage synchronizer for every bus input; idle bus level is all ones.
    logic [SW-1:0] meta_q;
    logic [SW-1:0] sync_q;
    logic          init_s, sync_s, din_s, dout_s, wtbt_s;
    logic [15:0]   ad_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= {bus.init_n, bus.sync_n, bus.din_n, bus.dout_n, bus.wtbt_n, bus.ad_in_n};
            sync_q <= meta_q;
        end
    end

    assign {init_s, sync_s, din_s, dout_s, wtbt_s, ad_s} = sync_q;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW:0]   a_q, a_d;
    logic          sel_q, sel_d;
    logic          rply_q, rply_d;
    logic          oe_q, oe_d;
    logic [15:0]   ad_out_q, ad_out_d;
    logic          sync_prev_q;
    logic          wr_en;

    logic [15:0]   addr_in;
    logic          sync_fall;
    logic          in_win;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic [15:0]   wdata;
    logic [1:0]    be;

    assign addr_in   = ~ad_s;
    assign wdata     = ~ad_s;
    assign sync_fall = sync_prev_q & ~sync_s;
    assign in_win    = ({1'b0, addr_in} >= WIN_LO) && ({1'b0, addr_in} < WIN_HI);
    assign be        = wtbt_s ? 2'b11 : (a_q[0] ? 2'b10 : 2'b01);

    // While idle the RAM is addressed straight from the bus so the word is ready
    // one clock after the address is latched, even if DIN follows immediately.
    assign rd_addr = (state_q == IDLE) ? addr_in[AW:1] : a_q[AW:1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [2**AW];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    mem[a_q[AW:1]] <= wdata[8*gi +: 8];
                end
                rd_q <= mem[rd_addr];
            end

            assign rd_data[8*gi +: 8] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            sel_q       <= 1'b0;
            rply_q      <= 1'b1;
            oe_q        <= 1'b0;
            ad_out_q    <= '1;
            sync_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            sel_q       <= sel_d;
            rply_q      <= rply_d;
            oe_q        <= oe_d;
            ad_out_q    <= ad_out_d;
            sync_prev_q <= sync_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        sel_d    = sel_q;
        rply_d   = rply_q;
        oe_d     = oe_q;
        ad_out_d = ad_out_q;
        wr_en    = 1'b0;

        // SYNC negation or INIT outranks everything, including a write due this edge.
        if (state_q != IDLE && (sync_s || !init_s)) begin
            state_d  = IDLE;
            sel_d    = 1'b0;
            rply_d   = 1'b1;
            oe_d     = 1'b0;
            ad_out_d = '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync_fall && init_s) begin
                        a_d = addr_in[AW:0];
                        if (in_win) begin
                            sel_d   = 1'b1;
                            state_d = ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (!din_s) begin
                        oe_d     = 1'b1;
                        ad_out_d = ~rd_data;
                        if (WAIT == 0) begin
                            rply_d  = 1'b0;
                            state_d = RD_HOLD;
                        end else begin
                            cnt_d   = WAIT_M1;
                            state_d = RD_WAIT;
                        end
                    end else if (!dout_s) begin
                        if (WAIT == 0) begin
                            wr_en   = 1'b1;
                            rply_d  = 1'b0;
                            state_d = WR_HOLD;
                        end else begin
                            cnt_d   = WAIT_M1;
                            state_d = WR_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (din_s) begin
                        oe_d     = 1'b0;
                        ad_out_d = '1;
                        state_d  = ADDR;
                    end else if (cnt_q == 4'd0) begin
                        rply_d  = 1'b0;
                        state_d = RD_HOLD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RD_HOLD: begin
                    if (din_s) begin
                        rply_d   = 1'b1;
                        oe_d     = 1'b0;
                        ad_out_d = '1;
                        state_d  = ADDR;
                    end
                end
                WR_WAIT: begin
                    if (dout_s) begin
                        state_d = ADDR;
                    end else if (cnt_q == 4'd0) begin
                        wr_en   = 1'b1;
                        rply_d  = 1'b0;
                        state_d = WR_HOLD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                WR_HOLD: begin
                    if (dout_s) begin
                        rply_d  = 1'b1;
                        state_d = ADDR;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.ad_out_n = ad_out_q;
    assign bus.ad_oe    = oe_q;
    assign bus.rply_n   = rply_q;
    assign bus.sel      = sel_q;
endmodule
